// File: rtl/bpf_bank_sequencer.sv
// Time-shares one band-pass IIR core across NUM_BANDS bands per audio sample and
// keeps a decaying peak-hold power level per band for the spectrum visualizer.
module bpf_bank_sequencer #(
    parameter int unsigned NUM_BANDS    = 6,
    parameter int unsigned POWER_W      = 11,
    parameter int unsigned DECAY_PERIOD = 256,
    parameter int unsigned DECAY_SHIFT  = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic [15:0]                   iAud_L,
    output logic                          sample_ready,
    output logic [2:0]                    band_sel,
    output logic                          bpf_start,
    output logic [15:0]                   bpf_x,
    input  logic                          bpf_done,
    input  logic [POWER_W-1:0]            bpf_power,
    output logic [NUM_BANDS*POWER_W-1:0]  oLevel,
    output logic                          frame_done,
    output logic                          overrun,
    output logic                          timeout_err,
    input  logic                          clear_err
);

    localparam int unsigned BAND_W = 3;
    localparam int unsigned SCNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int unsigned WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_FINISH
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WCNT_W-1:0]   wait_q;
    logic [SCNT_W-1:0]   scnt_q;
    logic [POWER_W-1:0]  cap_q;
    logic                accept;
    logic                busy_strobe;
    logic                timeout_hit;
    logic                last_band;
    logic                decay_now;

    // Decay step always removes at least 1 so small levels still reach zero.
    function automatic logic [POWER_W-1:0] decay_level(input logic [POWER_W-1:0] lv);
        logic [POWER_W-1:0] step;
        step = lv >> DECAY_SHIFT;
        if (step == '0 && lv != '0) begin
            step = POWER_W'(1);
        end
        return lv - step;
    endfunction

    // Next-state and per-cycle decode.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        decay_now   = 1'b0;
        last_band   = (band_sel == BAND_W'(NUM_BANDS - 1));
        busy_strobe = sample_valid && (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    accept  = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (bpf_done) begin
                    state_d = S_CAPTURE;
                end else if (wait_q == WCNT_W'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = last_band ? S_FINISH : S_LAUNCH;
            S_FINISH: begin
                decay_now = (scnt_q == SCNT_W'(DECAY_PERIOD - 1));
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers; strobes are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sample_ready <= 1'b1;
            bpf_start    <= 1'b0;
            frame_done   <= 1'b0;
            band_sel     <= '0;
            bpf_x        <= '0;
            wait_q       <= '0;
            scnt_q       <= '0;
            cap_q        <= '0;
        end else begin
            state_q      <= state_d;
            sample_ready <= (state_d == S_IDLE);
            bpf_start    <= (state_d == S_LAUNCH);
            frame_done   <= (state_d == S_FINISH);
            if (accept) begin
                bpf_x <= iAud_L;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        band_sel <= '0;
                    end
                end
                S_LAUNCH: wait_q <= '0;
                S_WAIT: begin
                    if (bpf_done) begin
                        cap_q <= bpf_power;
                    end else if (timeout_hit) begin
                        cap_q <= '0;
                    end else begin
                        wait_q <= wait_q + WCNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (!last_band) begin
                        band_sel <= band_sel + BAND_W'(1);
                    end
                end
                S_FINISH: begin
                    band_sel <= '0;
                    scnt_q   <= decay_now ? '0 : scnt_q + SCNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Sticky error flags; a new set condition beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (busy_strobe) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    // Peak-hold levels: capture in CAPTURE, decay in FINISH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oLevel <= '0;
        end else begin
            for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                if (state_q == S_CAPTURE && band_sel == BAND_W'(b) &&
                    cap_q > oLevel[b*POWER_W +: POWER_W]) begin
                    oLevel[b*POWER_W +: POWER_W] <= cap_q;
                end else if (decay_now) begin
                    oLevel[b*POWER_W +: POWER_W] <= decay_level(oLevel[b*POWER_W +: POWER_W]);
                end
            end
        end
    end

endmodule

// File: tb/tb_bpf_bank_sequencer.sv
// Directed bench for bpf_bank_sequencer with a behavioural BPF core responder.
module tb_bpf_bank_sequencer;

    localparam int unsigned NB = 6;
    localparam int unsigned PW = 11;

    logic           clk;
    logic           reset;
    logic           sample_valid;
    logic [15:0]    iAud_L;
    logic           sample_ready;
    logic [2:0]     band_sel;
    logic           bpf_start;
    logic [15:0]    bpf_x;
    logic           bpf_done;
    logic [PW-1:0]  bpf_power;
    logic [NB*PW-1:0] oLevel;
    logic           frame_done;
    logic           overrun;
    logic           timeout_err;
    logic           clear_err;

    int errors = 0;
    int checks = 0;
    int dly = 3;
    int hang_band = -1;
    logic [PW-1:0] pw [NB];
    int exp_lvl [NB];
    int st_cnt = 0;
    int fd_cnt = 0;
    logic [2:0]  st_band [256];
    logic [15:0] st_x [256];

    bpf_bank_sequencer #(
        .NUM_BANDS(6), .POWER_W(11), .DECAY_PERIOD(4), .DECAY_SHIFT(4), .TIMEOUT(255)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .iAud_L(iAud_L),
        .sample_ready(sample_ready), .band_sel(band_sel), .bpf_start(bpf_start),
        .bpf_x(bpf_x), .bpf_done(bpf_done), .bpf_power(bpf_power), .oLevel(oLevel),
        .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err),
        .clear_err(clear_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BPF core model: done 'dly' cycles after start, silent for hang_band.
    initial begin
        int cnt;
        logic [PW-1:0] mp;
        cnt = 0;
        mp = '0;
        bpf_done = 1'b0;
        bpf_power = '0;
        forever begin
            @(negedge clk);
            bpf_done = 1'b0;
            bpf_power = '0;
            if (!reset) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bpf_done = 1'b1;
                    bpf_power = mp;
                end
            end else if (bpf_start && int'(band_sel) != hang_band) begin
                cnt = dly;
                mp = pw[band_sel];
            end
        end
    end

    // Monitor: log every start (band, sample) and count frame_done cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (bpf_start) begin
                st_band[st_cnt % 256] = band_sel;
                st_x[st_cnt % 256] = bpf_x;
                st_cnt++;
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lvl(input int b);
        return int'(oLevel[b*PW +: PW]);
    endfunction

    task automatic chk_levels(input string tag);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s_band%0d", tag, b), 32'(lvl(b)), 32'(exp_lvl[b]));
        end
    endtask

    task automatic set_pw(input int a, input int b, input int c, input int d, input int e, input int f);
        pw[0] = PW'(a); pw[1] = PW'(b); pw[2] = PW'(c);
        pw[3] = PW'(d); pw[4] = PW'(e); pw[5] = PW'(f);
    endtask

    task automatic set_exp(input int a, input int b, input int c, input int d, input int e, input int f);
        exp_lvl[0] = a; exp_lvl[1] = b; exp_lvl[2] = c;
        exp_lvl[3] = d; exp_lvl[4] = e; exp_lvl[5] = f;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    // Send one sample; optionally strobe sample_valid (and clear_err) at cycle pulse_at.
    task automatic run_frame(input logic [15:0] d, input int pulse_at, input logic clr_at,
                             output int lat, output logic fd_after);
        logic got;
        got = 1'b0;
        lat = 0;
        @(negedge clk);
        sample_valid = 1'b1;
        iAud_L = d;
        while (!got && lat < 3000) begin
            @(negedge clk);
            lat++;
            sample_valid = (lat == pulse_at);
            clear_err = clr_at && (lat == pulse_at);
            iAud_L = (lat == pulse_at) ? 16'hDEAD : d;
            if (frame_done) got = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        clear_err = 1'b0;
        iAud_L = d;
        fd_after = frame_done;
        if (!got) lat = -1;
    endtask

    task automatic chk_frame(input string tag, input int base, input int fdb, input int lat,
                             input int exp_lat, input logic fd_after, input logic [15:0] x);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (st_band[(base + i) % 256] != 3'(i) || st_x[(base + i) % 256] != x) ok = 1'b0;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_starts"}, 32'(st_cnt - base), 32'd6);
        chk({tag, "_band_seq"}, 32'(ok), 32'd1);
        chk({tag, "_frame_done_cnt"}, 32'(fd_cnt - fdb), 32'd1);
        chk({tag, "_frame_done_width"}, 32'(fd_after), 32'd0);
        chk({tag, "_bpf_x"}, 32'(bpf_x), 32'(x));
    endtask

    initial begin
        int base;
        int fdb;
        int lat;
        logic fda;
        reset = 1'b0;
        sample_valid = 1'b0;
        iAud_L = '0;
        clear_err = 1'b0;
        set_pw(0, 0, 0, 0, 0, 0);
        set_exp(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        chk("rst_sample_ready", 32'(sample_ready), 32'd1);
        chk("rst_band_sel", 32'(band_sel), 32'd0);
        chk("rst_bpf_start", 32'(bpf_start), 32'd0);
        chk("rst_bpf_x", 32'(bpf_x), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk_levels("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: basic sequencing, powers 100..105.
        set_pw(100, 101, 102, 103, 104, 105);
        base = st_cnt; fdb = fd_cnt;
        run_frame(16'h1234, 0, 1'b0, lat, fda);
        chk_frame("f1", base, fdb, lat, 31, fda, 16'h1234);
        set_exp(100, 101, 102, 103, 104, 105);
        chk_levels("f1");
        chk("f1_ready", 32'(sample_ready), 32'd1);

        // Frame 2: lower powers hold the peaks; overrun strobe during band 0 WAIT.
        set_pw(50, 50, 50, 50, 50, 50);
        base = st_cnt; fdb = fd_cnt;
        run_frame(16'h0BEE, 3, 1'b0, lat, fda);
        chk_frame("f2", base, fdb, lat, 31, fda, 16'h0BEE);
        chk_levels("f2");
        chk("f2_overrun", 32'(overrun), 32'd1);
        pulse_clear();
        chk("f2_clear_overrun", 32'(overrun), 32'd0);

        // Frame 3: band 2 peak rises; overrun in FINISH together with clear_err.
        set_pw(0, 0, 200, 0, 0, 0);
        base = st_cnt; fdb = fd_cnt;
        run_frame(16'h0C0C, 31, 1'b1, lat, fda);
        chk_frame("f3", base, fdb, lat, 31, fda, 16'h0C0C);
        set_exp(100, 101, 200, 103, 104, 105);
        chk_levels("f3");
        chk("f3_overrun_set_wins", 32'(overrun), 32'd1);
        base = st_cnt;
        repeat (4) @(negedge clk);
        chk("f3_no_extra_frame", 32'(st_cnt - base), 32'd0);
        chk("f3_ready", 32'(sample_ready), 32'd1);
        pulse_clear();
        chk("f3_clear_overrun", 32'(overrun), 32'd0);

        // Frame 4: fourth frame since reset triggers decay.
        set_pw(0, 0, 0, 0, 0, 0);
        base = st_cnt; fdb = fd_cnt;
        run_frame(16'h0D0D, 0, 1'b0, lat, fda);
        chk_frame("f4", base, fdb, lat, 31, fda, 16'h0D0D);
        set_exp(94, 95, 188, 97, 98, 99);
        chk_levels("f4");

        // Frame 5: band 3 never completes.
        set_pw(0, 0, 0, 500, 120, 130);
        hang_band = 3;
        chk("f5_timeout_before", 32'(timeout_err), 32'd0);
        base = st_cnt; fdb = fd_cnt;
        run_frame(16'h0E0E, 0, 1'b0, lat, fda);
        hang_band = -1;
        chk_frame("f5", base, fdb, lat, 284, fda, 16'h0E0E);
        set_exp(94, 95, 188, 97, 120, 130);
        chk_levels("f5");
        chk("f5_timeout_err", 32'(timeout_err), 32'd1);
        chk("f5_overrun", 32'(overrun), 32'd0);
        pulse_clear();
        chk("f5_clear_timeout", 32'(timeout_err), 32'd0);

        // Async reset during band 2 WAIT.
        set_pw(7, 7, 7, 7, 7, 7);
        base = st_cnt; fdb = fd_cnt;
        @(negedge clk);
        sample_valid = 1'b1;
        iAud_L = 16'h5A5A;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("rm_pre_band_sel", 32'(band_sel), 32'd2);
        chk("rm_pre_starts", 32'(st_cnt - base), 32'd3);
        #1 reset = 1'b0;
        #1;
        set_exp(0, 0, 0, 0, 0, 0);
        chk_levels("rm");
        chk("rm_band_sel", 32'(band_sel), 32'd0);
        chk("rm_bpf_x", 32'(bpf_x), 32'd0);
        chk("rm_bpf_start", 32'(bpf_start), 32'd0);
        chk("rm_sample_ready", 32'(sample_ready), 32'd1);
        chk("rm_frame_done", 32'(frame_done), 32'd0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rm_no_frame_done", 32'(fd_cnt - fdb), 32'd0);

        // Frames 7-10: decay boundary values after counter restart.
        set_pw(10, 0, 16, 15, 1, 2047);
        base = st_cnt; fdb = fd_cnt;
        run_frame(16'h8001, 0, 1'b0, lat, fda);
        chk_frame("f7", base, fdb, lat, 31, fda, 16'h8001);
        set_exp(10, 0, 16, 15, 1, 2047);
        chk_levels("f7");
        set_pw(0, 0, 0, 0, 0, 0);
        run_frame(16'h0001, 0, 1'b0, lat, fda);
        run_frame(16'h0002, 0, 1'b0, lat, fda);
        chk_levels("f9");
        base = st_cnt; fdb = fd_cnt;
        run_frame(16'h0003, 0, 1'b0, lat, fda);
        chk_frame("f10", base, fdb, lat, 31, fda, 16'h0003);
        set_exp(9, 0, 15, 14, 0, 1920);
        chk_levels("f10");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
